// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared constants, size encodings and helpers for the
// memory arbiter slice.
package mem_arbiter_pkg;

  localparam int          DATA_WIDTH = 32;
  localparam logic [31:0] ZERO_DATA  = 32'h0000_0000;

  // LSB access size encodings; 2'b11 is illegal and handled as a word
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // addr[17:16] value that selects the memory-mapped IO region
  localparam logic [1:0] IO_ADDR_HI_DEFAULT = 2'b11;

  // Number of byte beats an access of the given size needs
  function automatic logic [2:0] size_to_len(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester, ROB and RAM-port signals of the memory arbiter.
// The slave modport is the arbiter; master is its environment.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic                  in_fetcher_ce;
  logic [DATA_WIDTH-1:0] in_fetcher_pc;
  logic                  out_fetcher_ce;
  logic [DATA_WIDTH-1:0] out_fetcher_instr;

  logic                  in_lsb_ce;
  logic                  in_lsb_rw;
  logic [DATA_WIDTH-1:0] in_lsb_addr;
  logic [1:0]            in_lsb_size;
  logic [DATA_WIDTH-1:0] in_lsb_data;
  logic                  out_lsb_ce;
  logic [DATA_WIDTH-1:0] out_lsb_data;

  logic                  in_rob_misbranch;

  logic                  out_ram_rw;
  logic [DATA_WIDTH-1:0] out_ram_addr;
  logic [7:0]            out_ram_data;
  logic [7:0]            in_ram_data;
  logic                  in_io_buffer_full;

  modport slave (
    input  in_fetcher_ce, in_fetcher_pc,
    output out_fetcher_ce, out_fetcher_instr,
    input  in_lsb_ce, in_lsb_rw, in_lsb_addr, in_lsb_size, in_lsb_data,
    output out_lsb_ce, out_lsb_data,
    input  in_rob_misbranch,
    output out_ram_rw, out_ram_addr, out_ram_data,
    input  in_ram_data, in_io_buffer_full
  );

  modport master (
    output in_fetcher_ce, in_fetcher_pc,
    input  out_fetcher_ce, out_fetcher_instr,
    output in_lsb_ce, in_lsb_rw, in_lsb_addr, in_lsb_size, in_lsb_data,
    input  out_lsb_ce, out_lsb_data,
    output in_rob_misbranch,
    input  out_ram_rw, out_ram_addr, out_ram_data,
    output in_ram_data, in_io_buffer_full
  );

endinterface

// File: rtl/mem_req_slot.sv
// mem_req_slot: holds one latched request pulse until the arbiter grants it.
// A flush drops a held read and refuses a read arriving in the same cycle;
// writes survive a flush.
module mem_req_slot
  import mem_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  set,
  input  logic                  clear,
  input  logic                  flush,
  input  logic                  set_rw,
  input  logic [DATA_WIDTH-1:0] set_addr,
  input  logic [1:0]            set_size,
  input  logic [DATA_WIDTH-1:0] set_data,
  output logic                  pending,
  output logic                  rw,
  output logic [DATA_WIDTH-1:0] addr,
  output logic [1:0]            size,
  output logic [DATA_WIDTH-1:0] data
);

  // Latch a new request (overwriting any held one), otherwise drop on grant or flush
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      rw      <= 1'b0;
      addr    <= ZERO_DATA;
      size    <= SIZE_BYTE;
      data    <= ZERO_DATA;
    end else if (en) begin
      if (set && !(flush && !set_rw)) begin
        pending <= 1'b1;
        rw      <= set_rw;
        addr    <= set_addr;
        size    <= set_size;
        data    <= set_data;
      end else if (clear || (flush && !rw)) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the fetcher or the LSB access to the byte-wide RAM/IO
// port, splits accesses into byte beats and assembles little-endian reads.
// Optional macro MEM_ARB_ROUND_ROBIN_EN: alternate grants on contention
// instead of fixed LSB priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter logic [1:0] IO_ADDR_HI = IO_ADDR_HI_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t                state, state_d;
  logic                  src_lsb, src_lsb_d;
  logic [DATA_WIDTH-1:0] base, base_d;
  logic [2:0]            len, len_d;
  logic [DATA_WIDTH-1:0] wdata, wdata_d;
  logic [2:0]            cnt, cnt_d;
  logic [DATA_WIDTH-1:0] rbuf, rbuf_d;
  logic [1:0]            rd_idx;

  logic                  ram_rw_d;
  logic [DATA_WIDTH-1:0] ram_addr_d;
  logic [7:0]            ram_data_d;
  logic                  fetch_ce_d, lsb_ce_d;
  logic [DATA_WIDTH-1:0] fetch_instr_d, lsb_data_d;

  logic                  f_pending, f_rw, l_pending, l_rw;
  logic [DATA_WIDTH-1:0] f_addr, f_data, l_addr, l_data;
  logic [1:0]            f_size, l_size;
  logic                  f_req, l_req, sel_lsb, grant;
  logic                  sel_rw, grant_stall, cur_stall;
  logic [DATA_WIDTH-1:0] sel_addr, sel_data;
  logic [1:0]            sel_size;

  mem_req_slot u_fetch_slot (
    .clk(clk), .rst(rst), .en(rdy),
    .set(bus.in_fetcher_ce), .clear(grant && !sel_lsb), .flush(bus.in_rob_misbranch),
    .set_rw(1'b0), .set_addr(bus.in_fetcher_pc), .set_size(SIZE_WORD), .set_data(ZERO_DATA),
    .pending(f_pending), .rw(f_rw), .addr(f_addr), .size(f_size), .data(f_data)
  );

  mem_req_slot u_lsb_slot (
    .clk(clk), .rst(rst), .en(rdy),
    .set(bus.in_lsb_ce), .clear(grant && sel_lsb), .flush(bus.in_rob_misbranch),
    .set_rw(bus.in_lsb_rw), .set_addr(bus.in_lsb_addr), .set_size(bus.in_lsb_size),
    .set_data(bus.in_lsb_data),
    .pending(l_pending), .rw(l_rw), .addr(l_addr), .size(l_size), .data(l_data)
  );

  // A read is not granted on the very edge where a misbranch flushes it
  assign f_req = f_pending && !bus.in_rob_misbranch;
  assign l_req = l_pending && !(bus.in_rob_misbranch && !l_rw);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_fetch;

  // Remember who was served last; starting at "fetch" lets the LSB win first
  always_ff @(posedge clk) begin
    if (rst)
      last_fetch <= 1'b1;
    else if (rdy && grant)
      last_fetch <= !sel_lsb;
  end

  assign sel_lsb = l_req && (!f_req || last_fetch);
`else
  assign sel_lsb = l_req;
`endif

  assign sel_rw      = sel_lsb ? l_rw   : f_rw;
  assign sel_addr    = sel_lsb ? l_addr : f_addr;
  assign sel_size    = sel_lsb ? l_size : f_size;
  assign sel_data    = sel_lsb ? l_data : f_data;
  assign grant_stall = (sel_addr[17:16] == IO_ADDR_HI) && bus.in_io_buffer_full;
  assign cur_stall   = (base[17:16] == IO_ADDR_HI) && bus.in_io_buffer_full;

  // Next-state and next registered outputs; cnt counts edges since grant in
  // READ and completed beats in WRITE
  always_comb begin
    state_d       = state;
    src_lsb_d     = src_lsb;
    base_d        = base;
    len_d         = len;
    wdata_d       = wdata;
    cnt_d         = cnt;
    rbuf_d        = rbuf;
    rd_idx        = cnt[1:0] - 2'd2;
    ram_rw_d      = 1'b0;
    ram_addr_d    = ZERO_DATA;
    ram_data_d    = 8'h00;
    fetch_ce_d    = 1'b0;
    fetch_instr_d = bus.out_fetcher_instr;
    lsb_ce_d      = 1'b0;
    lsb_data_d    = bus.out_lsb_data;
    grant         = 1'b0;
    case (state)
      IDLE: begin
        if (f_req || l_req) begin
          grant      = 1'b1;
          src_lsb_d  = sel_lsb;
          base_d     = sel_addr;
          len_d      = size_to_len(sel_size);
          wdata_d    = sel_data;
          rbuf_d     = ZERO_DATA;
          ram_addr_d = sel_addr;
          if (sel_rw) begin
            state_d = WRITE;
            if (grant_stall) begin
              cnt_d = 3'd0;
            end else begin
              ram_rw_d   = 1'b1;
              ram_data_d = sel_data[7:0];
              cnt_d      = 3'd1;
            end
          end else begin
            state_d = READ;
            cnt_d   = 3'd1;
          end
        end
      end
      READ: begin
        if (bus.in_rob_misbranch) begin
          state_d = IDLE;
        end else begin
          if (cnt < len)
            ram_addr_d = base + 32'(cnt);
          if (cnt >= 3'd2)
            rbuf_d[{rd_idx, 3'b000} +: 8] = bus.in_ram_data;
          if (cnt == len + 3'd1) begin
            state_d = IDLE;
            if (src_lsb) begin
              lsb_ce_d   = 1'b1;
              lsb_data_d = rbuf_d;
            end else begin
              fetch_ce_d    = 1'b1;
              fetch_instr_d = rbuf_d;
            end
          end else begin
            cnt_d = cnt + 3'd1;
          end
        end
      end
      WRITE: begin
        if (cnt == len) begin
          state_d  = IDLE;
          lsb_ce_d = 1'b1;
        end else begin
          ram_addr_d = base + 32'(cnt);
          if (!cur_stall) begin
            ram_rw_d   = 1'b1;
            ram_data_d = wdata[{cnt[1:0], 3'b000} +: 8];
            cnt_d      = cnt + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, access context and all port outputs; everything holds while rdy is low
  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= IDLE;
      src_lsb               <= 1'b0;
      base                  <= ZERO_DATA;
      len                   <= 3'd0;
      wdata                 <= ZERO_DATA;
      cnt                   <= 3'd0;
      rbuf                  <= ZERO_DATA;
      bus.out_ram_rw        <= 1'b0;
      bus.out_ram_addr      <= ZERO_DATA;
      bus.out_ram_data      <= 8'h00;
      bus.out_fetcher_ce    <= 1'b0;
      bus.out_fetcher_instr <= ZERO_DATA;
      bus.out_lsb_ce        <= 1'b0;
      bus.out_lsb_data      <= ZERO_DATA;
    end else if (rdy) begin
      state                 <= state_d;
      src_lsb               <= src_lsb_d;
      base                  <= base_d;
      len                   <= len_d;
      wdata                 <= wdata_d;
      cnt                   <= cnt_d;
      rbuf                  <= rbuf_d;
      bus.out_ram_rw        <= ram_rw_d;
      bus.out_ram_addr      <= ram_addr_d;
      bus.out_ram_data      <= ram_data_d;
      bus.out_fetcher_ce    <= fetch_ce_d;
      bus.out_fetcher_instr <= fetch_instr_d;
      bus.out_lsb_ce        <= lsb_ce_d;
      bus.out_lsb_data      <= lsb_data_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter with a
// registered byte-wide RAM model.
module tb_mem_arbiter;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    bit          is_read;
  } exp_t;

  logic clk, rst, rdy;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   c;
  exp_t fq[$];
  exp_t lq[$];
  logic [7:0] ram [bit [31:0]];

  mem_arbiter_if bus ();

  mem_arbiter dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered RAM: write on rw, return the sampled address's byte next cycle
  always @(posedge clk) begin
    if (bus.out_ram_rw) ram[bus.out_ram_addr] = bus.out_ram_data;
    bus.in_ram_data <= ram.exists(bus.out_ram_addr) ? ram[bus.out_ram_addr] : 8'h00;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input bit to_fetch, input logic [31:0] data, input int at, input bit is_read);
    exp_t e;
    e.data = data;
    e.cyc = at;
    e.is_read = is_read;
    if (to_fetch) fq.push_back(e);
    else lq.push_back(e);
  endtask

  // One cycle of request/misbranch inputs, released after the sampling edge
  task automatic applyStimulus(input bit do_f, input logic [31:0] pc, input bit do_l, input bit rw,
                               input logic [31:0] addr, input logic [1:0] size,
                               input logic [31:0] data, input bit mb);
    bus.in_fetcher_ce    = do_f;
    bus.in_fetcher_pc    = pc;
    bus.in_lsb_ce        = do_l;
    bus.in_lsb_rw        = rw;
    bus.in_lsb_addr      = addr;
    bus.in_lsb_size      = size;
    bus.in_lsb_data      = data;
    bus.in_rob_misbranch = mb;
    step();
    bus.in_fetcher_ce    = 1'b0;
    bus.in_lsb_ce        = 1'b0;
    bus.in_rob_misbranch = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && (fq.size() != 0 || lq.size() != 0); i++) step();
    checkOutput("scoreboard_drained", 32'(fq.size() + lq.size()), 32'd0);
    repeat (4) step();
  endtask

  // Scoreboard: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (bus.out_fetcher_ce) begin
      checkOutput("fetch_pulse_expected", 32'(fq.size() != 0), 32'd1);
      if (fq.size() != 0) begin
        e = fq.pop_front();
        checkOutput("fetch_instr", bus.out_fetcher_instr, e.data);
        checkOutput("fetch_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (bus.out_lsb_ce) begin
      checkOutput("lsb_pulse_expected", 32'(lq.size() != 0), 32'd1);
      if (lq.size() != 0) begin
        e = lq.pop_front();
        if (e.is_read) checkOutput("lsb_data", bus.out_lsb_data, e.data);
        checkOutput("lsb_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h05; ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
    ram[32'h2000] = 8'h11; ram[32'h2001] = 8'h22; ram[32'h2002] = 8'h33; ram[32'h2003] = 8'h44;
    ram[32'h0102] = 8'h77;
    bus.in_fetcher_ce = 1'b0; bus.in_fetcher_pc = 32'h0;
    bus.in_lsb_ce = 1'b0; bus.in_lsb_rw = 1'b0; bus.in_lsb_addr = 32'h0;
    bus.in_lsb_size = 2'b00; bus.in_lsb_data = 32'h0;
    bus.in_rob_misbranch = 1'b0; bus.in_io_buffer_full = 1'b0;
    rst = 1'b1; rdy = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    checkOutput("reset_fetcher_ce", 32'(bus.out_fetcher_ce), 32'd0);
    checkOutput("reset_lsb_ce", 32'(bus.out_lsb_ce), 32'd0);
    checkOutput("reset_ram_rw", 32'(bus.out_ram_rw), 32'd0);
    checkOutput("reset_ram_addr", bus.out_ram_addr, 32'd0);
    checkOutput("reset_ram_data", 32'(bus.out_ram_data), 32'd0);
    checkOutput("reset_instr", bus.out_fetcher_instr, 32'd0);
    checkOutput("reset_lsb_data", bus.out_lsb_data, 32'd0);

    $display("[TB] fetch at 0x1000");
    c = cyc;
    push_exp(1, 32'h0000_0513, c + 7, 1);
    applyStimulus(1, 32'h1000, 0, 0, 32'h0, 2'b00, 32'h0, 0);
    step();
    checkOutput("fetch_grant_addr", bus.out_ram_addr, 32'h1000);
    checkOutput("fetch_grant_rw", 32'(bus.out_ram_rw), 32'd0);
    wait_done(30);

    $display("[TB] fetch and LSB word read contend");
    c = cyc;
    push_exp(0, 32'h4433_2211, c + 7, 1);
    push_exp(1, 32'h0000_0513, c + 13, 1);
    applyStimulus(1, 32'h1000, 1, 0, 32'h2000, 2'b10, 32'h0, 0);
    wait_done(40);

    $display("[TB] second contention after an LSB grant");
    c = cyc;
    push_exp(0, 32'h0000_0011, c + 4, 1);
    applyStimulus(0, 32'h0, 1, 0, 32'h2000, 2'b00, 32'h0, 0);
    step();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    push_exp(1, 32'h0000_0513, c + 10, 1);
    push_exp(0, 32'h0000_4433, c + 14, 1);
`else
    push_exp(0, 32'h0000_4433, c + 8, 1);
    push_exp(1, 32'h0000_0513, c + 14, 1);
`endif
    applyStimulus(1, 32'h1000, 1, 0, 32'h2002, 2'b01, 32'h0, 0);
    wait_done(40);

    $display("[TB] LSB half-word write to 0x100");
    c = cyc;
    push_exp(0, 32'h0, c + 4, 0);
    applyStimulus(0, 32'h0, 1, 1, 32'h100, 2'b01, 32'hABCD_1234, 0);
    wait_done(30);
    checkOutput("ram_0x100", 32'(ram[32'h100]), 32'h34);
    checkOutput("ram_0x101", 32'(ram[32'h101]), 32'h12);
    checkOutput("ram_0x102", 32'(ram[32'h102]), 32'h77);

    $display("[TB] IO write stalled by full buffer");
    bus.in_io_buffer_full = 1'b1;
    c = cyc;
    push_exp(0, 32'h0, c + 6, 0);
    applyStimulus(0, 32'h0, 1, 1, 32'h0003_0000, 2'b00, 32'h0000_005A, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("io_stall_rw", 32'(bus.out_ram_rw), 32'd0);
    end
    bus.in_io_buffer_full = 1'b0;
    step();
    checkOutput("io_beat_rw", 32'(bus.out_ram_rw), 32'd1);
    checkOutput("io_beat_addr", bus.out_ram_addr, 32'h0003_0000);
    checkOutput("io_beat_data", 32'(bus.out_ram_data), 32'h5A);
    wait_done(30);
    checkOutput("ram_io", 32'(ram[32'h0003_0000]), 32'h5A);

    $display("[TB] misbranch during fetch with pending store");
    c = cyc;
    push_exp(0, 32'h0, c + 7, 0);
    applyStimulus(1, 32'h1000, 0, 0, 32'h0, 2'b00, 32'h0, 0);
    applyStimulus(0, 32'h0, 1, 1, 32'h104, 2'b00, 32'h0000_00EE, 0);
    step();
    step();
    checkOutput("fetch_byte2_addr", bus.out_ram_addr, 32'h1002);
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 2'b00, 32'h0, 1);
    checkOutput("abort_addr", bus.out_ram_addr, 32'h0);
    wait_done(30);
    checkOutput("ram_store_after_flush", 32'(ram[32'h104]), 32'hEE);

    $display("[TB] reset mid-read after rdy stall");
    applyStimulus(1, 32'h1000, 0, 0, 32'h0, 2'b00, 32'h0, 0);
    step();
    step();
    rdy = 1'b0;
    step();
    step();
    checkOutput("rdy_hold_addr", bus.out_ram_addr, 32'h1001);
    rst = 1'b1;
    rdy = 1'b1;
    step();
    checkOutput("midreset_ram_addr", bus.out_ram_addr, 32'h0);
    checkOutput("midreset_instr", bus.out_fetcher_instr, 32'h0);
    checkOutput("midreset_lsb_data", bus.out_lsb_data, 32'h0);
    checkOutput("midreset_fetcher_ce", 32'(bus.out_fetcher_ce), 32'd0);
    rst = 1'b0;
    c = cyc;
    push_exp(1, 32'h0000_0513, c + 7, 1);
    applyStimulus(1, 32'h1000, 0, 0, 32'h0, 2'b00, 32'h0, 0);
    wait_done(30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Memory arbiter/sequencer between the single byte-wide RAM/IO port and its two requesters: the instruction fetcher (4-byte reads) and the load/store buffer (1/2/4-byte reads and writes). Latches single-cycle request pulses, grants one requester at a time, and splits each access into byte beats on the RAM port. Assembles little-endian read data and returns it with a one-cycle done pulse. Aborts speculative reads on ROB misbranch.

## Interface
Parameters:
- IO_ADDR_HI, 2'b11, value of addr[17:16] that marks the memory-mapped IO region.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- rdy  in  1  global enable; when low, all state and outputs hold.
- in_fetcher_ce  in  1  one-cycle pulse: fetch request.
- in_fetcher_pc  in  32  fetch address, sampled with the pulse.
- out_fetcher_ce  out  1  one-cycle pulse: instruction valid.
- out_fetcher_instr  out  32  fetched instruction.
- in_lsb_ce  in  1  one-cycle pulse: LSB request.
- in_lsb_rw  in  1  1 = write, 0 = read.
- in_lsb_addr  in  32  byte address.
- in_lsb_size  in  2  00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes; 11 is illegal and treated as 4.
- in_lsb_data  in  32  write data; low bytes used.
- out_lsb_ce  out  1  one-cycle pulse: access done (read data valid, or write complete).
- out_lsb_data  out  32  read data, zero-extended; the LSB sign-extends.
- in_rob_misbranch  in  1  flush.
- out_ram_rw  out  1  1 = write.
- out_ram_addr  out  32  byte address.
- out_ram_data  out  8  write byte.
- in_ram_data  in  8  read byte; valid in the cycle after the RAM samples the address.
- in_io_buffer_full  in  1  IO write buffer full.

## Operation
- Pending slots: one per requester. A pulse sets the slot and latches addr, size, rw and data. The slot clears when granted.
- States:
  - IDLE: if a slot is pending, grant it (LSB first by default) and go to READ or WRITE.
  - READ: byte k address = base+k for k < n. Byte k captured into bits [8k+7:8k] two edges after its address is driven.
  - WRITE: out_ram_rw=1 and drives byte k of the data at base+k, one byte per cycle.
- Done pulse is a single cycle. The FSM then returns to IDLE with out_ram_rw=0 and out_ram_addr=0.
- IO stall: in WRITE, if addr[17:16]==IO_ADDR_HI and in_io_buffer_full=1:
  - drive out_ram_rw=0 and do not advance the beat counter;
  - retry the same byte next cycle.
- Misbranch:
  - Clears the fetcher slot and the LSB slot if it holds a read.
  - An active fetch or LSB read aborts to IDLE with no done pulse, and in-flight return bytes are discarded.
  - An active write, or a pending write slot, is unaffected.
  - A request pulse arriving in the same cycle as misbranch is dropped if it is a fetch or read.
- A new pulse while the same requester's slot is still pending overwrites the slot (protocol violation; not expected).
- Reset values:
  - all *_ce outputs = 0, out_ram_rw = 0;
  - all addr/data outputs = 0;
  - slots empty, state IDLE.
- Reset mid-access abandons the access with no pulse.

## Timing
- Request pulse at edge E0 is latched; grant at E1 if IDLE, which drives the byte-0 address.
- Read of n bytes granted at edge G: addresses driven G..G+n-1; captures at G+2..G+n+1; done pulse registered at G+n+1. Fetch: pulse at G+5.
- Write of n bytes: beats G..G+n-1; done pulse registered at G+n, absent stalls.
- Back-to-back: the next grant occurs on the edge after the done pulse edge; IDLE lasts at least one cycle.
- Grant uses the slot contents as of the grant edge, including a pulse latched on the previous edge.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: when both slots are pending, grant alternates. The last-served requester loses the tie; after reset the LSB wins first.
- Undefined: fixed priority, LSB always beats the fetcher.

## Structure
- Shared constant header (already included codebase-wide) holds:
  - `DATA_WIDTH, `TRUE/`FALSE, `ZERO_DATA;
  - new size encodings and IO_ADDR_HI default.
- FSM state localparams stay local.
- One sub-module, mem_req_slot: a pulse-latched request holder with set/clear/flush. Instantiated twice.

## Test plan
- Fetch at 0x0000_1000, RAM holds 13 05 00 00 -> out_fetcher_instr=0x00000513 with the pulse exactly 5 edges after grant.
- Fetch and LSB 4-byte read pulse in the same cycle -> LSB served first, fetch granted the edge after the LSB done pulse; with round-robin enabled, second contention goes to the fetcher.
- LSB write size 01, addr 0x100, data 0xABCD1234 -> RAM 0x100=0x34, 0x101=0x12; 0x102 untouched; done pulse at G+2.
- LSB 1-byte write to 0x30000 with in_io_buffer_full high 3 cycles -> rw stays 0 for 3 cycles, then one write beat, done pulse.
- Misbranch during fetch byte 2 -> no out_fetcher_ce; a concurrent pending store still completes.
- rst asserted mid-read, with rdy held low 2 cycles beforehand -> outputs zero, and the next fetch after release behaves normally.
